// File: rtl/spi_gain_writer.sv
// SPI master that writes a pre-amplifier gain word and sends RESET_GAIN after every reset.
// Define GAIN_READBACK_EN to capture MISO into prev_gain; otherwise prev_gain is tied to zero.
module spi_gain_writer #(
  parameter int               WIDTH      = 8,
  parameter int               CLK_DIV    = 2,
  parameter int               CS_SETUP   = 2,
  parameter int               CS_HOLD    = 2,
  parameter logic [WIDTH-1:0] RESET_GAIN = WIDTH'(8'h11)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] gain_word,
  output logic             busy,
  output logic             done,
  output logic             spi_sck,
  output logic             spi_mosi,
  output logic             amp_cs,
  input  logic             spi_miso,
  output logic [WIDTH-1:0] prev_gain
);

  localparam int BW   = $clog2(WIDTH);
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] SETUP_LAST = PW'(CS_SETUP - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(CS_HOLD - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DW-1:0]    div_q, div_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             cs_q, cs_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             init_q, init_d;
  logic [WIDTH-1:0] load_word;

`ifdef GAIN_READBACK_EN
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] prev_q, prev_d;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    div_d     = div_q;
    ph_d      = ph_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    init_d    = init_q;
    load_word = init_q ? RESET_GAIN : gain_word;
`ifdef GAIN_READBACK_EN
    cap_d     = cap_q;
    prev_d    = prev_q;
`endif

    case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        // The power-on word takes priority over any pending start request.
        if (init_q || (start && !busy_q)) begin
          shreg_d = load_word;
          mosi_d  = load_word[WIDTH-1];
          init_d  = 1'b0;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          ph_d    = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (ph_q == SETUP_LAST) begin
          ph_d    = '0;
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sck_d = !sck_q;
          if (!sck_q) begin
`ifdef GAIN_READBACK_EN
            cap_d = {cap_q[WIDTH-2:0], spi_miso};
`endif
          end else if (bit_q == BIT_LAST) begin
            // Last falling edge: MOSI keeps the final bit through the hold time.
            bit_d   = '0;
            ph_d    = '0;
            state_d = HOLD;
          end else begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            mosi_d  = shreg_q[WIDTH-2];
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HOLD: begin
        sck_d = 1'b0;
        if (ph_q == HOLD_LAST) begin
          ph_d    = '0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef GAIN_READBACK_EN
          prev_d  = cap_q;
`endif
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= RESET_GAIN;
      bit_q   <= '0;
      div_q   <= '0;
      ph_q    <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      init_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      init_q  <= init_d;
    end
  end

`ifdef GAIN_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q  <= '0;
      prev_q <= '0;
    end else begin
      cap_q  <= cap_d;
      prev_q <= prev_d;
    end
  end

  assign prev_gain = prev_q;
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign prev_gain   = '0;
`endif

  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign amp_cs   = cs_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_gain_writer.sv
// Scoreboard bench for spi_gain_writer: a bus monitor decodes each chip-select frame and
// the scenario tasks compare the decoded frames against the words they queued.
module tb_spi_gain_writer;

  localparam int W        = 8;
  localparam int CLK_DIV  = 2;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int TXN_LEN  = CS_SETUP + 2 * CLK_DIV * W + CS_HOLD;

`ifdef GAIN_READBACK_EN
  localparam logic [W-1:0] EXP_RB = 8'h5A;
`else
  localparam logic [W-1:0] EXP_RB = 8'h00;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] gain_word;
  logic         busy;
  logic         done;
  logic         spi_sck;
  logic         spi_mosi;
  logic         amp_cs;
  logic         spi_miso;
  logic [W-1:0] prev_gain;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] word;
    int           nbits;
    int           len;
    bit           ok;
  } obs_t;

  obs_t         obs_q[$];
  logic [W-1:0] exp_q[$];

  logic [W-1:0] miso_pat;
  logic [3:0]   nfalls;

  spi_gain_writer #(
    .WIDTH     (W),
    .CLK_DIV   (CLK_DIV),
    .CS_SETUP  (CS_SETUP),
    .CS_HOLD   (CS_HOLD),
    .RESET_GAIN(8'h11)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .gain_word(gain_word),
    .busy     (busy),
    .done     (done),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .amp_cs   (amp_cs),
    .spi_miso (spi_miso),
    .prev_gain(prev_gain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Amplifier model: presents the next MISO bit after every SCK fall.
  assign spi_miso = (nfalls < 4'd8) ? miso_pat[3'(7 - nfalls)] : 1'b0;

  // Bus monitor: sampled on the falling clk edge, records word, frame length and SCK/MOSI shape.
  initial begin
    bit           in_txn = 0;
    logic         prev_cs = 1'b1;
    logic         prev_sck = 1'b0;
    logic         prev_mosi = 1'b0;
    logic [W-1:0] m_word = '0;
    int           m_nbits = 0;
    int           m_len = 0;
    int           run = 0;
    bit           m_ok = 1;
    nfalls = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_txn = 0;
        nfalls = '0;
      end else begin
        if (prev_cs && !amp_cs) begin
          in_txn = 1; m_word = '0; m_nbits = 0; m_len = 0; run = 0; m_ok = 1; nfalls = '0;
        end
        if (in_txn) begin
          if (!amp_cs) m_len++;
          if (spi_sck && !prev_sck) begin
            if ((m_nbits == 0) ? (run != CS_SETUP + CLK_DIV) : (run != CLK_DIV)) m_ok = 0;
            if (spi_mosi !== prev_mosi) m_ok = 0;
            m_word = {m_word[W-2:0], spi_mosi};
            m_nbits++;
            run = 1;
          end else if (!spi_sck && prev_sck) begin
            if (run != CLK_DIV) m_ok = 0;
            nfalls = nfalls + 4'd1;
            run = 1;
          end else begin
            run++;
          end
          if (amp_cs && !prev_cs) begin
            obs_q.push_back('{word: m_word, nbits: m_nbits, len: m_len, ok: m_ok});
            in_txn = 0;
          end
        end
      end
      prev_cs   = amp_cs;
      prev_sck  = spi_sck;
      prev_mosi = spi_mosi;
    end
  end

  task automatic wait_done(output int cycles, output bit ok);
    cycles = 0;
    ok = 0;
    while (cycles < 200 && !ok) begin
      @(posedge clk); #1;
      cycles++;
      if (done === 1'b1) ok = 1;
    end
  endtask

  task automatic get_obs(output obs_t o, output bit got, output logic [W-1:0] e);
    for (int i = 0; i < 4 && obs_q.size() == 0; i++) @(negedge clk);
    got = (obs_q.size() > 0);
    if (got) o = obs_q.pop_front();
    e = (exp_q.size() > 0) ? exp_q[0] : 'x;
    if (exp_q.size() > 0) exp_q.delete(0);
  endtask

  task automatic test_reset;
    int c; bit ok, got; obs_t o; logic [W-1:0] e;
    rst = 1'b1; start = 1'b0; gain_word = '0; miso_pat = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({amp_cs, spi_sck, spi_mosi, done, busy, prev_gain} !== {5'b10001, 8'h00}) begin
      errors++;
      $display("FAIL reset_values: cs/sck/mosi/done/busy/prev = %b %b %b %b %b %h, want 1 0 0 0 1 00",
               amp_cs, spi_sck, spi_mosi, done, busy, prev_gain);
    end
    exp_q.push_back(8'h11);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (amp_cs !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL init_first_edge: amp_cs=%b busy=%b, want 0 1", amp_cs, busy);
    end
    wait_done(c, ok);
    checks++;
    if (!ok || c != TXN_LEN) begin
      errors++;
      $display("FAIL init_done_latency: got %0d cycles (seen=%0d), want %0d", c, ok, TXN_LEN);
    end
    checks++;
    if (busy !== 1'b0 || amp_cs !== 1'b1) begin
      errors++;
      $display("FAIL init_busy_at_done: busy=%b amp_cs=%b, want 0 1", busy, amp_cs);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL init_done_width: done=%b one cycle later, want 0", done);
    end
    get_obs(o, got, e);
    checks++;
    if (!got || o.word !== e || o.nbits != W || o.len != TXN_LEN || !o.ok) begin
      errors++;
      $display("FAIL init_frame: got=%0d word=%h bits=%0d len=%0d shape=%0d, want %h %0d %0d 1",
               got, o.word, o.nbits, o.len, o.ok, e, W, TXN_LEN);
    end
  endtask

  task automatic test_write;
    int c; bit ok, got; obs_t o; logic [W-1:0] e;
    @(posedge clk); #1;
    gain_word = 8'hA5; start = 1'b1;
    exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (amp_cs !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_accept: amp_cs=%b busy=%b, want 0 1", amp_cs, busy);
    end
    wait_done(c, ok);
    checks++;
    if (!ok || c != TXN_LEN) begin
      errors++;
      $display("FAIL write_done_latency: got %0d cycles (seen=%0d), want %0d", c, ok, TXN_LEN);
    end
    get_obs(o, got, e);
    checks++;
    if (!got || o.word !== e || o.nbits != W || o.len != TXN_LEN || !o.ok) begin
      errors++;
      $display("FAIL write_frame: got=%0d word=%h bits=%0d len=%0d shape=%0d, want %h %0d %0d 1",
               got, o.word, o.nbits, o.len, o.ok, e, W, TXN_LEN);
    end
  endtask

  task automatic test_ignore_start;
    int c, extra; bit ok, got; obs_t o; logic [W-1:0] e;
    @(posedge clk); #1;
    gain_word = 8'hA5; start = 1'b1;
    exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    gain_word = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(c, ok);
    checks++;
    if (!ok || c + 16 != TXN_LEN) begin
      errors++;
      $display("FAIL ignore_done_latency: got %0d cycles (seen=%0d), want %0d", c + 16, ok, TXN_LEN);
    end
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1 || amp_cs !== 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_no_second: %0d active cycles after done, want 0", extra);
    end
    get_obs(o, got, e);
    checks++;
    if (!got || o.word !== e || o.nbits != W || o.len != TXN_LEN || !o.ok) begin
      errors++;
      $display("FAIL ignore_frame: got=%0d word=%h bits=%0d len=%0d shape=%0d, want %h %0d %0d 1",
               got, o.word, o.nbits, o.len, o.ok, e, W, TXN_LEN);
    end
  endtask

  task automatic test_back_to_back;
    int c, low; bit ok, got; obs_t o; logic [W-1:0] e;
    @(posedge clk); #1;
    gain_word = 8'h3C; start = 1'b1;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h3C);
    wait_done(c, ok);
    checks++;
    if (!ok || c != TXN_LEN + 1 || amp_cs !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: %0d edges (seen=%0d) amp_cs=%b, want %0d 1", c, ok, amp_cs, TXN_LEN + 1);
    end
    @(posedge clk); #1;
    checks++;
    if (amp_cs !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: amp_cs=%b busy=%b one cycle after done, want 0 1", amp_cs, busy);
    end
    wait_done(c, ok);
    start = 1'b0;
    checks++;
    if (!ok || c != TXN_LEN) begin
      errors++;
      $display("FAIL b2b_second_done: got %0d cycles (seen=%0d), want %0d", c, ok, TXN_LEN);
    end
    low = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (amp_cs !== 1'b1) low++;
    end
    checks++;
    if (low != 0) begin
      errors++;
      $display("FAIL b2b_stop: amp_cs low %0d cycles after start dropped, want 0", low);
    end
    for (int k = 0; k < 2; k++) begin
      get_obs(o, got, e);
      checks++;
      if (!got || o.word !== e || o.nbits != W || o.len != TXN_LEN || !o.ok) begin
        errors++;
        $display("FAIL b2b_frame%0d: got=%0d word=%h bits=%0d len=%0d shape=%0d, want %h %0d %0d 1",
                 k, got, o.word, o.nbits, o.len, o.ok, e, W, TXN_LEN);
      end
    end
  endtask

  task automatic test_readback;
    int c; bit ok, got; obs_t o; logic [W-1:0] e;
    @(posedge clk); #1;
    miso_pat = 8'h5A;
    gain_word = 8'h96; start = 1'b1;
    exp_q.push_back(8'h96);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(c, ok);
    checks++;
    if (!ok || prev_gain !== EXP_RB) begin
      errors++;
      $display("FAIL readback_prev_gain: got %h (seen=%0d), want %h", prev_gain, ok, EXP_RB);
    end
    get_obs(o, got, e);
    checks++;
    if (!got || o.word !== e || o.nbits != W || o.len != TXN_LEN || !o.ok) begin
      errors++;
      $display("FAIL readback_frame: got=%0d word=%h bits=%0d len=%0d shape=%0d, want %h %0d %0d 1",
               got, o.word, o.nbits, o.len, o.ok, e, W, TXN_LEN);
    end
    miso_pat = '0;
  endtask

  task automatic test_reset_mid;
    int c; bit ok, got; obs_t o; logic [W-1:0] e;
    @(posedge clk); #1;
    gain_word = 8'hA5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (spi_sck !== 1'b1 || amp_cs !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pulse4: spi_sck=%b amp_cs=%b before reset, want 1 0", spi_sck, amp_cs);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({amp_cs, spi_sck, spi_mosi, done, busy, prev_gain} !== {5'b10001, 8'h00}) begin
      errors++;
      $display("FAIL midreset_async: cs/sck/mosi/done/busy/prev = %b %b %b %b %b %h, want 1 0 0 0 1 00",
               amp_cs, spi_sck, spi_mosi, done, busy, prev_gain);
    end
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(8'h11);
    rst = 1'b0;
    wait_done(c, ok);
    checks++;
    if (!ok || c != TXN_LEN + 1) begin
      errors++;
      $display("FAIL midreset_restart: done after %0d edges (seen=%0d), want %0d", c, ok, TXN_LEN + 1);
    end
    get_obs(o, got, e);
    checks++;
    if (!got || o.word !== e || o.nbits != W || o.len != TXN_LEN || !o.ok) begin
      errors++;
      $display("FAIL midreset_frame: got=%0d word=%h bits=%0d len=%0d shape=%0d, want %h %0d %0d 1",
               got, o.word, o.nbits, o.len, o.ok, e, W, TXN_LEN);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL stray_frames: %0d unexpected frames, want 0", obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_ignore_start();
    test_back_to_back();
    test_readback();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
